// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: DEPTH stages of {valid, data, ctrl}
// with stall/flush handling and saturating stall/flush event counters.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              cntClr,
  input  logic              validIn,
  input  logic [DATA_W-1:0] dataIn,
  input  logic [CTRL_W-1:0] ctrlIn,
  output logic              validOut,
  output logic [DATA_W-1:0] dataOut,
  output logic [CTRL_W-1:0] ctrlOut,
  output logic [CNT_W-1:0]  stallCnt,
  output logic [CNT_W-1:0]  flushCnt
);

  logic              valid_q [DEPTH];
  logic              valid_d [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];
  logic [CTRL_W-1:0] ctrl_q  [DEPTH];
  logic [CTRL_W-1:0] ctrl_d  [DEPTH];

  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              any_valid;

  // Stage next-state: flush beats stall beats shift; data survives a flush.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i];
      data_d[i]  = data_q[i];
      ctrl_d[i]  = ctrl_q[i];
    end
    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid_d[i] = 1'b0;
        ctrl_d[i]  = '0;
      end
    end else if (!stall) begin
      valid_d[0] = validIn;
      data_d[0]  = dataIn;
      ctrl_d[0]  = validIn ? ctrlIn : '0;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        data_d[i]  = data_q[i-1];
        ctrl_d[i]  = ctrl_q[i-1];
      end
    end
  end

  // A flush only counts when it actually squashes something.
  always_comb begin
    any_valid = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      any_valid = any_valid | valid_q[i];
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cntClr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall && !flush && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush && any_valid && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
        ctrl_q[i]  <= '0;
      end
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid_q[i] <= valid_d[i];
        data_q[i]  <= data_d[i];
        ctrl_q[i]  <= ctrl_d[i];
      end
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign validOut = valid_q[DEPTH-1];
  assign dataOut  = data_q[DEPTH-1];
  assign ctrlOut  = ctrl_q[DEPTH-1];
  assign stallCnt = stall_cnt_q;
  assign flushCnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: three instances (DEPTH=3, DEPTH=1, CNT_W=2).
module tb_pipe_stage_reg;

  logic clk;
  int   checks;
  int   errors;

  // Instance A: DEPTH=3
  logic        a_rst, a_stall, a_flush, a_clr, a_vin;
  logic [31:0] a_din;
  logic [15:0] a_cin;
  logic        a_vout;
  logic [31:0] a_dout;
  logic [15:0] a_cout;
  logic [7:0]  a_scnt, a_fcnt;

  // Instance B: DEPTH=1
  logic        b_rst, b_stall, b_flush, b_clr, b_vin;
  logic [31:0] b_din;
  logic [15:0] b_cin;
  logic        b_vout;
  logic [31:0] b_dout;
  logic [15:0] b_cout;
  logic [7:0]  b_scnt, b_fcnt;

  // Instance C: DEPTH=1, CNT_W=2
  logic        c_rst, c_stall, c_flush, c_clr, c_vin;
  logic [31:0] c_din;
  logic [15:0] c_cin;
  logic        c_vout;
  logic [31:0] c_dout;
  logic [15:0] c_cout;
  logic [1:0]  c_scnt, c_fcnt;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .DEPTH(3), .CNT_W(8)) u_a (
    .clk(clk), .rst(a_rst), .stall(a_stall), .flush(a_flush), .cntClr(a_clr),
    .validIn(a_vin), .dataIn(a_din), .ctrlIn(a_cin),
    .validOut(a_vout), .dataOut(a_dout), .ctrlOut(a_cout),
    .stallCnt(a_scnt), .flushCnt(a_fcnt)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .DEPTH(1), .CNT_W(8)) u_b (
    .clk(clk), .rst(b_rst), .stall(b_stall), .flush(b_flush), .cntClr(b_clr),
    .validIn(b_vin), .dataIn(b_din), .ctrlIn(b_cin),
    .validOut(b_vout), .dataOut(b_dout), .ctrlOut(b_cout),
    .stallCnt(b_scnt), .flushCnt(b_fcnt)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .DEPTH(1), .CNT_W(2)) u_c (
    .clk(clk), .rst(c_rst), .stall(c_stall), .flush(c_flush), .cntClr(c_clr),
    .validIn(c_vin), .dataIn(c_din), .ctrlIn(c_cin),
    .validOut(c_vout), .dataOut(c_dout), .ctrlOut(c_cout),
    .stallCnt(c_scnt), .flushCnt(c_fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    a_rst = 1'b1; a_stall = 1'b0; a_flush = 1'b0; a_clr = 1'b0; a_vin = 1'b0; a_din = '0; a_cin = '0;
    b_rst = 1'b1; b_stall = 1'b0; b_flush = 1'b0; b_clr = 1'b0; b_vin = 1'b0; b_din = '0; b_cin = '0;
    c_rst = 1'b1; c_stall = 1'b0; c_flush = 1'b0; c_clr = 1'b0; c_vin = 1'b0; c_din = '0; c_cin = '0;
    tick();

    // Reset state
    chk("a_rst_vout", 32'(a_vout), 32'd0);
    chk("a_rst_dout", a_dout, 32'd0);
    chk("a_rst_cout", 32'(a_cout), 32'd0);
    chk("a_rst_scnt", 32'(a_scnt), 32'd0);
    chk("a_rst_fcnt", 32'(a_fcnt), 32'd0);
    chk("b_rst_vout", 32'(b_vout), 32'd0);
    chk("c_rst_scnt", 32'(c_scnt), 32'd0);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

    // DEPTH=3 fill: first value reaches the output after the third edge
    a_vin = 1'b1; a_din = 32'hA1; a_cin = 16'h0011;
    tick();
    chk("a_fill_e1_vout", 32'(a_vout), 32'd0);
    a_din = 32'hB2; a_cin = 16'h0022;
    tick();
    a_din = 32'hC3; a_cin = 16'h0033;
    tick();
    chk("a_e3_vout", 32'(a_vout), 32'd1);
    chk("a_e3_dout", a_dout, 32'hA1);
    chk("a_e3_cout", 32'(a_cout), 32'h0011);
    a_din = 32'hD4; a_cin = 16'h0044;
    tick();
    chk("a_e4_dout", a_dout, 32'hB2);
    chk("a_e4_cout", 32'(a_cout), 32'h0022);
    a_din = 32'hE5; a_cin = 16'h0055;
    tick();
    chk("a_e5_dout", a_dout, 32'hC3);

    // Stall holds the full pipe
    a_stall = 1'b1; a_din = 32'hF6; a_cin = 16'h0066;
    tick();
    chk("a_stall_dout", a_dout, 32'hC3);
    chk("a_stall_vout", 32'(a_vout), 32'd1);
    chk("a_stall_scnt", 32'(a_scnt), 32'd1);

    // Reset mid-stream with stall asserted
    a_rst = 1'b1;
    tick();
    chk("a_mrst_vout", 32'(a_vout), 32'd0);
    chk("a_mrst_dout", a_dout, 32'd0);
    chk("a_mrst_cout", 32'(a_cout), 32'd0);
    chk("a_mrst_scnt", 32'(a_scnt), 32'd0);
    chk("a_mrst_fcnt", 32'(a_fcnt), 32'd0);

    // Refill after release; trailing bubble carries ctrl=0 despite ctrlIn
    a_rst = 1'b0; a_stall = 1'b0; a_vin = 1'b1; a_din = 32'h55; a_cin = 16'h0005;
    tick();
    chk("a_refill_e1_vout", 32'(a_vout), 32'd0);
    a_vin = 1'b0; a_din = 32'h0; a_cin = 16'hFFFF;
    tick();
    tick();
    chk("a_refill_vout", 32'(a_vout), 32'd1);
    chk("a_refill_dout", a_dout, 32'h55);
    chk("a_refill_cout", 32'(a_cout), 32'h0005);
    tick();
    chk("a_bubble_vout", 32'(a_vout), 32'd0);
    chk("a_bubble_cout", 32'(a_cout), 32'd0);

    // DEPTH=1 load then stall 4 cycles with new inputs
    b_vin = 1'b1; b_din = 32'h1234; b_cin = 16'h00FF;
    tick();
    chk("b_load_vout", 32'(b_vout), 32'd1);
    chk("b_load_dout", b_dout, 32'h1234);
    chk("b_load_cout", 32'(b_cout), 32'h00FF);
    b_stall = 1'b1; b_din = 32'hDEAD; b_cin = 16'h0F0F;
    repeat (4) tick();
    chk("b_stall_vout", 32'(b_vout), 32'd1);
    chk("b_stall_dout", b_dout, 32'h1234);
    chk("b_stall_cout", 32'(b_cout), 32'h00FF);
    chk("b_stall_scnt", 32'(b_scnt), 32'd4);

    // Flush wins over stall; data survives
    b_flush = 1'b1;
    tick();
    chk("b_flush_vout", 32'(b_vout), 32'd0);
    chk("b_flush_cout", 32'(b_cout), 32'd0);
    chk("b_flush_dout", b_dout, 32'h1234);
    chk("b_flush_fcnt", 32'(b_fcnt), 32'd1);
    chk("b_flush_scnt", 32'(b_scnt), 32'd4);

    // Bubble with ctrlIn all ones, counters cleared in the same cycle
    b_flush = 1'b0; b_stall = 1'b0; b_vin = 1'b0; b_din = 32'h7777; b_cin = 16'hFFFF; b_clr = 1'b1;
    tick();
    chk("b_bub_vout", 32'(b_vout), 32'd0);
    chk("b_bub_cout", 32'(b_cout), 32'd0);
    chk("b_bub_dout", b_dout, 32'h7777);
    chk("b_clr_scnt", 32'(b_scnt), 32'd0);
    chk("b_clr_fcnt", 32'(b_fcnt), 32'd0);

    // Flush on an empty pipe is not counted; inputs discarded
    b_clr = 1'b0; b_flush = 1'b1; b_vin = 1'b1; b_din = 32'h9999; b_cin = 16'h1111;
    tick();
    chk("b_eflush_fcnt", 32'(b_fcnt), 32'd0);
    chk("b_eflush_dout", b_dout, 32'h7777);
    chk("b_eflush_vout", 32'(b_vout), 32'd0);
    b_flush = 1'b0;

    // CNT_W=2 saturation and clear
    c_stall = 1'b1;
    repeat (3) tick();
    chk("c_scnt_3", 32'(c_scnt), 32'd3);
    repeat (3) tick();
    chk("c_scnt_sat", 32'(c_scnt), 32'd3);
    chk("c_sat_vout", 32'(c_vout), 32'd0);
    c_clr = 1'b1;
    tick();
    chk("c_clr_scnt", 32'(c_scnt), 32'd0);
    c_clr = 1'b0;
    tick();
    chk("c_after_clr_scnt", 32'(c_scnt), 32'd1);
    c_stall = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
